// File: rtl/ah_func_ci_ctrl_pkg.sv
// Shared constants for the custom-instruction controller and its function pipeline:
// FSM state encoding and the default pipeline latency.
package ah_func_ci_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ci_state_t;

  localparam int DEF_LATENCY = 62;

endpackage

// File: rtl/ah_func_ci_ctrl.sv
// Nios II multi-cycle custom-instruction front end for a fixed-latency, free-running function pipeline.
// Optional macro AH_FUNC_CI_STATS_EN adds a 32-bit completed-operation counter output.
module ah_func_ci_ctrl
  import ah_func_ci_ctrl_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] pipe_a,
  output logic [DATA_W-1:0] pipe_b,
  input  logic [DATA_W-1:0] pipe_result,
  output logic              err_busy
`ifdef AH_FUNC_CI_STATS_EN
  ,
  output logic [31:0]       op_count
`endif
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  ci_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_result, r_pipe_a, r_pipe_b;
  logic             r_err_busy;
  logic             w_accept, w_reject, w_capture, w_exit;

  assign w_accept  = clk_en && start && (r_state == ST_IDLE);
  assign w_reject  = clk_en && start && (r_state != ST_IDLE);
  assign w_capture = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));
  assign w_exit    = (r_state == ST_DONE) && clk_en;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_capture) w_state_nxt = ST_DONE;
      ST_DONE: if (w_exit)    w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // The pipeline never stalls, so the countdown ignores clk_en once BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_result   <= '0;
      r_pipe_a   <= '0;
      r_pipe_b   <= '0;
      r_err_busy <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= CNT_W'(LATENCY);
        r_pipe_a <= dataa;
        r_pipe_b <= datab;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= w_capture ? '0 : r_cnt - CNT_W'(1);
      end
      if (w_capture) r_result   <= pipe_result;
      if (w_reject)  r_err_busy <= 1'b1;
    end
  end

`ifdef AH_FUNC_CI_STATS_EN
  logic [31:0] r_op_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_op_count <= '0;
    else if (w_exit) r_op_count <= r_op_count + 32'd1;
  end
  assign op_count = r_op_count;
`endif

  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign pipe_a   = r_pipe_a;
  assign pipe_b   = r_pipe_b;
  assign err_busy = r_err_busy;

endmodule
